// File: rtl/kgp_branch_pkg.sv
// Shared definitions for the KGP-RISC branch/flag stage: branch codes, flag bit
// positions, the link register and the squash FSM state type.
package kgp_branch_pkg;

  typedef enum logic [3:0] {
    BT_NONE = 4'd0,
    BT_B    = 4'd1,
    BT_BR   = 4'd2,
    BT_BL   = 4'd3,
    BT_BLTZ = 4'd4,
    BT_BZ   = 4'd5,
    BT_BNZ  = 4'd6,
    BT_BCY  = 4'd7,
    BT_BNCY = 4'd8
  } br_type_t;

  localparam int FLAG_CARRY = 2;
  localparam int FLAG_NEG   = 1;
  localparam int FLAG_ZERO  = 0;

  localparam logic [4:0] LINK_REG = 5'd31;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } bfu_state_t;

  // Codes above BT_NBCY are unassigned and behave as ordinary ALU results.
  function automatic logic is_branch(input logic [3:0] t);
    return (t >= 4'd1) && (t <= 4'd8);
  endfunction

endpackage

// File: rtl/wb_skid_buffer.sv
// Two-entry valid/ready FIFO feeding writeback. The head register drives the
// outputs directly, so they hold their last value once the buffer drains.
module wb_skid_buffer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [XLEN-1:0] push_data,
  input  logic [4:0]      push_rd,
  input  logic            push_we,
  output logic            can_push,
  input  logic            pop_ready,
  output logic            head_valid,
  output logic [XLEN-1:0] head_data,
  output logic [4:0]      head_rd,
  output logic            head_we
);

  logic [1:0]      count;
  logic [XLEN-1:0] tail_data;
  logic [4:0]      tail_rd;
  logic            tail_we;
  logic            do_push;
  logic            do_pop;

  assign can_push   = (count != 2'd2);
  assign head_valid = (count != 2'd0);
  assign do_push    = push && can_push;
  assign do_pop     = head_valid && pop_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= 2'd0;
      head_data <= '0;
      head_rd   <= '0;
      head_we   <= 1'b0;
    end else if (do_push && do_pop) begin
      // Only reachable at count 1: the new entry replaces the departing head.
      head_data <= push_data;
      head_rd   <= push_rd;
      head_we   <= push_we;
    end else if (do_push) begin
      if (count == 2'd0) begin
        head_data <= push_data;
        head_rd   <= push_rd;
        head_we   <= push_we;
      end
      count <= count + 2'd1;
    end else if (do_pop) begin
      if (count == 2'd2) begin
        head_data <= tail_data;
        head_rd   <= tail_rd;
        head_we   <= tail_we;
      end
      count <= count - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !do_pop && (count == 2'd1)) begin
      tail_data <= push_data;
      tail_rd   <= push_rd;
      tail_we   <= push_we;
    end
  end

endmodule

// File: rtl/branch_flag_unit.sv
// Branch resolution, carry flag and wrong-path squash stage after the ALU.
// Defining BRANCH_STATS_EN adds the stat_branches/stat_taken counter ports.
module branch_flag_unit
  import kgp_branch_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int SQUASH_DEPTH = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] alu_out,
  input  logic [2:0]      alu_flags,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] br_target,
  input  logic [3:0]      br_type,
  input  logic            flag_we,
  input  logic [4:0]      rd,
  input  logic            reg_we,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      wb_rd,
  output logic            wb_we,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            carry_q
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_taken
`endif
);

  bfu_state_t      state, state_d;
  logic [1:0]      sq_cnt, sq_cnt_d;
  logic            fire;
  logic            run_fire;
  logic            taken;
  logic [XLEN-1:0] target;
  logic            is_bl;
  logic            push;
  logic [XLEN-1:0] push_data;
  logic [4:0]      push_rd;

  assign fire     = in_valid && in_ready;
  assign run_fire = fire && (state == ST_RUN);
  assign is_bl    = (br_type == BT_BL);

  // Condition codes see carry_q before this transfer's own flag write.
  always_comb begin
    taken  = 1'b0;
    target = br_target;
    case (br_type_t'(br_type))
      BT_B, BT_BL: taken = 1'b1;
      BT_BR: begin
        taken  = 1'b1;
        target = alu_out;
      end
      BT_BLTZ: taken = alu_flags[FLAG_NEG];
      BT_BZ:   taken = alu_flags[FLAG_ZERO];
      BT_BNZ:  taken = !alu_flags[FLAG_ZERO];
      BT_BCY:  taken = carry_q;
      BT_BNCY: taken = !carry_q;
      default: taken = 1'b0;
    endcase
  end

  assign push      = run_fire && (is_bl || (!is_branch(br_type) && reg_we));
  assign push_data = is_bl ? (pc + XLEN'(4)) : alu_out;
  assign push_rd   = is_bl ? LINK_REG : rd;

  always_comb begin
    state_d  = state;
    sq_cnt_d = sq_cnt;
    case (state)
      ST_RUN: begin
        if (run_fire && taken && (SQUASH_DEPTH != 0)) begin
          state_d  = ST_SQUASH;
          sq_cnt_d = 2'(SQUASH_DEPTH);
        end
      end
      ST_SQUASH: begin
        if (fire) begin
          sq_cnt_d = sq_cnt - 2'd1;
          if (sq_cnt == 2'd1) state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_RUN;
      sq_cnt <= 2'd0;
    end else begin
      state  <= state_d;
      sq_cnt <= sq_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect    <= 1'b0;
      redirect_pc <= '0;
      carry_q     <= 1'b0;
    end else begin
      redirect <= run_fire && taken;
      if (run_fire && taken) redirect_pc <= target;
      if (run_fire && flag_we) carry_q <= alu_flags[FLAG_CARRY];
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches <= 32'd0;
      stat_taken    <= 32'd0;
    end else if (run_fire && is_branch(br_type)) begin
      stat_branches <= stat_branches + 32'd1;
      if (taken) stat_taken <= stat_taken + 32'd1;
    end
  end
`endif

  wb_skid_buffer #(
    .XLEN(XLEN)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .push_rd   (push_rd),
    .push_we   (1'b1),
    .can_push  (in_ready),
    .pop_ready (wb_ready),
    .head_valid(wb_valid),
    .head_data (wb_data),
    .head_rd   (wb_rd),
    .head_we   (wb_we)
  );

endmodule

// File: tb/tb_branch_flag_unit.sv
// Directed bench for branch_flag_unit (XLEN=32, SQUASH_DEPTH=1).
module tb_branch_flag_unit;
  import kgp_branch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] alu_out = '0;
  logic [2:0]  alu_flags = '0;
  logic [31:0] pc = '0;
  logic [31:0] br_target = '0;
  logic [3:0]  br_type = '0;
  logic        flag_we = 1'b0;
  logic [4:0]  rd = '0;
  logic        reg_we = 1'b0;
  logic        wb_valid;
  logic        wb_ready = 1'b1;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_we;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        carry_q;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_taken;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  branch_flag_unit #(.XLEN(32), .SQUASH_DEPTH(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_out(alu_out), .alu_flags(alu_flags), .pc(pc), .br_target(br_target),
    .br_type(br_type), .flag_we(flag_we), .rd(rd), .reg_we(reg_we),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_we(wb_we), .redirect(redirect), .redirect_pc(redirect_pc), .carry_q(carry_q)
`ifdef BRANCH_STATS_EN
    , .stat_branches(stat_branches), .stat_taken(stat_taken)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transfer presented for exactly one clock edge.
  task automatic xfer(input logic [3:0] t, input logic [31:0] a, input logic [2:0] f,
                      input logic [31:0] p, input logic [31:0] tg, input logic fwe,
                      input logic [4:0] r, input logic rwe);
    br_type = t; alu_out = a; alu_flags = f; pc = p; br_target = tg;
    flag_we = fwe; rd = r; reg_we = rwe; in_valid = 1'b1;
    step();
    in_valid = 1'b0; flag_we = 1'b0; reg_we = 1'b0; br_type = BT_NONE;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid: got %b want 0", wb_valid); end
    n_checks++; if (wb_data !== 32'h0) begin n_fail++; $display("FAIL reset_wb_data: got %h want 0", wb_data); end
    n_checks++; if (wb_rd !== 5'd0) begin n_fail++; $display("FAIL reset_wb_rd: got %0d want 0", wb_rd); end
    n_checks++; if (wb_we !== 1'b0) begin n_fail++; $display("FAIL reset_wb_we: got %b want 0", wb_we); end
    n_checks++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL reset_redirect: got %b want 0", redirect); end
    n_checks++; if (redirect_pc !== 32'h0) begin n_fail++; $display("FAIL reset_redirect_pc: got %h want 0", redirect_pc); end
    n_checks++; if (carry_q !== 1'b0) begin n_fail++; $display("FAIL reset_carry: got %b want 0", carry_q); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_flag_bcy();
    xfer(BT_NONE, 32'h1, 3'b100, 32'h10, 32'h0, 1'b1, 5'd0, 1'b0);
    n_checks++; if (carry_q !== 1'b1) begin n_fail++; $display("FAIL add_carry: got %b want 1", carry_q); end
    n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL add_noreg_wb_valid: got %b want 0", wb_valid); end
    xfer(BT_BCY, 32'h0, 3'b000, 32'h14, 32'h40, 1'b0, 5'd0, 1'b0);
    n_checks++; if (redirect !== 1'b1) begin n_fail++; $display("FAIL bcy_redirect: got %b want 1", redirect); end
    n_checks++; if (redirect_pc !== 32'h40) begin n_fail++; $display("FAIL bcy_redirect_pc: got %h want 40", redirect_pc); end
    xfer(BT_NONE, 32'h9, 3'b000, 32'h18, 32'h0, 1'b1, 5'd3, 1'b1);
    n_checks++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL bcy_pulse_end: got %b want 0", redirect); end
    n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL bcy_squash_wb: got %b want 0", wb_valid); end
    n_checks++; if (carry_q !== 1'b1) begin n_fail++; $display("FAIL bcy_squash_carry: got %b want 1", carry_q); end
    xfer(BT_NONE, 32'hA, 3'b000, 32'h1C, 32'h0, 1'b0, 5'd4, 1'b1);
    n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL post_squash_valid: got %b want 1", wb_valid); end
    n_checks++; if (wb_data !== 32'hA) begin n_fail++; $display("FAIL post_squash_data: got %h want a", wb_data); end
    n_checks++; if (wb_rd !== 5'd4) begin n_fail++; $display("FAIL post_squash_rd: got %0d want 4", wb_rd); end
    n_checks++; if (wb_we !== 1'b1) begin n_fail++; $display("FAIL post_squash_we: got %b want 1", wb_we); end
    step();
    n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid: got %b want 0", wb_valid); end
    n_checks++; if (wb_data !== 32'hA) begin n_fail++; $display("FAIL drain_hold_data: got %h want a", wb_data); end
  endtask

  task automatic test_bz_bnz();
    xfer(BT_BZ, 32'h0, 3'b001, 32'h20, 32'h80, 1'b0, 5'd0, 1'b0);
    n_checks++; if (redirect !== 1'b1) begin n_fail++; $display("FAIL bz_redirect: got %b want 1", redirect); end
    n_checks++; if (redirect_pc !== 32'h80) begin n_fail++; $display("FAIL bz_redirect_pc: got %h want 80", redirect_pc); end
    xfer(BT_NONE, 32'h33, 3'b000, 32'h24, 32'h0, 1'b0, 5'd6, 1'b1);
    n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL bz_squash_wb: got %b want 0", wb_valid); end
    xfer(BT_BNZ, 32'h0, 3'b001, 32'h80, 32'h90, 1'b0, 5'd0, 1'b0);
    n_checks++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL bnz_redirect: got %b want 0", redirect); end
    xfer(BT_NONE, 32'h55, 3'b000, 32'h84, 32'h0, 1'b0, 5'd7, 1'b1);
    n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL bnz_run_valid: got %b want 1", wb_valid); end
    n_checks++; if (wb_data !== 32'h55) begin n_fail++; $display("FAIL bnz_run_data: got %h want 55", wb_data); end
    step();
  endtask

  task automatic test_bl();
    xfer(BT_BL, 32'h0, 3'b000, 32'h100, 32'h200, 1'b0, 5'd5, 1'b0);
    n_checks++; if (redirect_pc !== 32'h200) begin n_fail++; $display("FAIL bl_redirect_pc: got %h want 200", redirect_pc); end
    n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL bl_wb_valid: got %b want 1", wb_valid); end
    n_checks++; if (wb_data !== 32'h104) begin n_fail++; $display("FAIL bl_wb_data: got %h want 104", wb_data); end
    n_checks++; if (wb_rd !== 5'd31) begin n_fail++; $display("FAIL bl_wb_rd: got %0d want 31", wb_rd); end
    n_checks++; if (wb_we !== 1'b1) begin n_fail++; $display("FAIL bl_wb_we: got %b want 1", wb_we); end
    xfer(BT_NONE, 32'hDEAD, 3'b000, 32'h104, 32'h0, 1'b0, 5'd8, 1'b1);
    n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL bl_squash_wb: got %b want 0", wb_valid); end
    n_checks++; if (wb_data !== 32'h104) begin n_fail++; $display("FAIL bl_hold_data: got %h want 104", wb_data); end
    xfer(BT_BL, 32'h0, 3'b000, 32'hFFFF_FFFC, 32'h300, 1'b0, 5'd2, 1'b0);
    n_checks++; if (wb_data !== 32'h0) begin n_fail++; $display("FAIL bl_wrap_data: got %h want 0", wb_data); end
    n_checks++; if (wb_rd !== 5'd31) begin n_fail++; $display("FAIL bl_wrap_rd: got %0d want 31", wb_rd); end
    n_checks++; if (redirect_pc !== 32'h300) begin n_fail++; $display("FAIL bl_wrap_redirect_pc: got %h want 300", redirect_pc); end
    xfer(BT_NONE, 32'h0, 3'b000, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic test_bltz_br();
    xfer(BT_BLTZ, 32'h0, 3'b000, 32'h30, 32'h700, 1'b0, 5'd0, 1'b0);
    n_checks++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL bltz_nt_redirect: got %b want 0", redirect); end
    xfer(BT_BLTZ, 32'h0, 3'b010, 32'h34, 32'h700, 1'b0, 5'd0, 1'b0);
    n_checks++; if (redirect_pc !== 32'h700) begin n_fail++; $display("FAIL bltz_redirect_pc: got %h want 700", redirect_pc); end
    xfer(BT_NONE, 32'h0, 3'b000, 32'h38, 32'h0, 1'b0, 5'd0, 1'b0);
    xfer(BT_BR, 32'h600, 3'b000, 32'h700, 32'h999, 1'b0, 5'd0, 1'b0);
    n_checks++; if (redirect !== 1'b1) begin n_fail++; $display("FAIL br_redirect: got %b want 1", redirect); end
    n_checks++; if (redirect_pc !== 32'h600) begin n_fail++; $display("FAIL br_redirect_pc: got %h want 600", redirect_pc); end
    xfer(BT_NONE, 32'h0, 3'b000, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic test_backpressure();
    wb_ready = 1'b0;
    xfer(BT_NONE, 32'd5, 3'b000, 32'h40, 32'h0, 1'b0, 5'd1, 1'b1);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_1: got %b want 1", in_ready); end
    xfer(BT_NONE, 32'd6, 3'b000, 32'h44, 32'h0, 1'b0, 5'd2, 1'b1);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full: got %b want 0", in_ready); end
    n_checks++; if (wb_data !== 32'd5) begin n_fail++; $display("FAIL bp_head_5: got %0d want 5", wb_data); end
    br_type = BT_NONE; alu_out = 32'd7; rd = 5'd3; reg_we = 1'b1; in_valid = 1'b1;
    step();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall_ready: got %b want 0", in_ready); end
    n_checks++; if (wb_rd !== 5'd1) begin n_fail++; $display("FAIL bp_stall_rd: got %0d want 1", wb_rd); end
    wb_ready = 1'b1;
    step();
    n_checks++; if (wb_data !== 32'd6) begin n_fail++; $display("FAIL bp_head_6: got %0d want 6", wb_data); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_again: got %b want 1", in_ready); end
    step();
    in_valid = 1'b0; reg_we = 1'b0;
    n_checks++; if (wb_data !== 32'd7) begin n_fail++; $display("FAIL bp_head_7: got %0d want 7", wb_data); end
    n_checks++; if (wb_rd !== 5'd3) begin n_fail++; $display("FAIL bp_rd_3: got %0d want 3", wb_rd); end
    n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_7: got %b want 1", wb_valid); end
    step();
    n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %b want 0", wb_valid); end
  endtask

  task automatic test_reset_mid_squash();
    xfer(BT_B, 32'h0, 3'b000, 32'h50, 32'h400, 1'b0, 5'd0, 1'b0);
    n_checks++; if (redirect !== 1'b1) begin n_fail++; $display("FAIL rms_redirect: got %b want 1", redirect); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++; if (redirect_pc !== 32'h0) begin n_fail++; $display("FAIL rms_redirect_pc: got %h want 0", redirect_pc); end
    n_checks++; if (carry_q !== 1'b0) begin n_fail++; $display("FAIL rms_carry: got %b want 0", carry_q); end
    n_checks++; if (wb_data !== 32'h0) begin n_fail++; $display("FAIL rms_wb_data: got %h want 0", wb_data); end
    xfer(BT_NONE, 32'h77, 3'b000, 32'h404, 32'h0, 1'b0, 5'd9, 1'b1);
    n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL rms_run_valid: got %b want 1", wb_valid); end
    n_checks++; if (wb_data !== 32'h77) begin n_fail++; $display("FAIL rms_run_data: got %h want 77", wb_data); end
    step();
  endtask

  task automatic test_bcy_same_cycle();
    xfer(BT_BCY, 32'h0, 3'b100, 32'h60, 32'h500, 1'b1, 5'd0, 1'b0);
    n_checks++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL bcy_same_redirect: got %b want 0", redirect); end
    n_checks++; if (carry_q !== 1'b1) begin n_fail++; $display("FAIL bcy_same_carry: got %b want 1", carry_q); end
    xfer(BT_NONE, 32'h12, 3'b000, 32'h64, 32'h0, 1'b0, 5'd2, 1'b1);
    n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL bcy_same_next: got %b want 1", wb_valid); end
    xfer(BT_BNCY, 32'h0, 3'b000, 32'h68, 32'h510, 1'b0, 5'd0, 1'b0);
    n_checks++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL bncy_redirect: got %b want 0", redirect); end
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_flag_bcy();
    test_bz_bnz();
    test_bl();
    test_bltz_br();
    test_backpressure();
    test_reset_mid_squash();
    test_bcy_same_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_flag_unit.md
Name: branch_flag_unit

Overview:
- Stage directly downstream of the KGP-RISC ALU.
- Accepts one ALU result per transfer, holds the architectural carry flag, and resolves all branch types.
- Issues a one-cycle PC redirect and squashes wrong-path results.
- Forwards surviving results to writeback through a 2-entry skid buffer with a valid/ready handshake.

Parameters:
- XLEN, 32, data and PC width.
- SQUASH_DEPTH, 1, number of accepted transfers dropped after a taken branch (0..3).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  ALU result valid
- in_ready  out  1  stage can accept
- alu_out  in  XLEN  ALU result
- alu_flags  in  3  {carry, negative, zero} from ALU
- pc  in  XLEN  PC of the instruction
- br_target  in  XLEN  decoded immediate branch target
- br_type  in  4  branch code (see package)
- flag_we  in  1  instruction updates the carry register
- rd  in  5  destination register
- reg_we  in  1  instruction writes the register file
- wb_valid  out  1  writeback entry valid
- wb_ready  in  1  writeback accepts
- wb_data  out  XLEN  value to write
- wb_rd  out  5  destination register
- wb_we  out  1  register write enable
- redirect  out  1  one-cycle pulse: fetch must load redirect_pc
- redirect_pc  out  XLEN  new PC
- carry_q  out  1  architectural carry flag

Behaviour:
- Transfer: occurs when in_valid and in_ready are both high. in_ready = (buffer count < 2).
- Reset (rst=1 at a clk edge): buffer emptied; wb_valid=0; wb_data=0; wb_rd=0; wb_we=0; redirect=0; redirect_pc=0; carry_q=0; squash counter=0; FSM=RUN. Reset mid-squash or mid-stall discards everything.
- FSM: two states, RUN and SQUASH.
  - RUN: each transfer is evaluated.
  - SQUASH: each transfer decrements sq_cnt and is dropped (no buffer write, no flag update, no redirect).
  - SQUASH -> RUN when sq_cnt reaches 0.
  - A taken branch in RUN loads sq_cnt = SQUASH_DEPTH and moves to SQUASH; if SQUASH_DEPTH = 0, the FSM stays in RUN.
- Branch conditions, evaluated in RUN:
  - B, BL: always taken.
  - BR: always taken; target = alu_out.
  - BLTZ: taken if alu_flags[1].
  - BZ: taken if alu_flags[0].
  - BNZ: taken if !alu_flags[0].
  - BCY: taken if carry_q.
  - BNCY: taken if !carry_q.
  - All types other than BR take their target from br_target.
  - BCY/BNCY read carry_q as it was before the current transfer.
- Redirect latency: on a taken transfer at edge N, redirect=1 and redirect_pc=target from edge N to edge N+1. The outputs are registered, so there is exactly one cycle of latency.
- BL: enqueues wb_data = pc + 4, wb_rd = 31, wb_we = 1, overriding rd and reg_we.
- Other branches: enqueue nothing.
- Non-branch instructions: enqueue {alu_out, rd, reg_we} if reg_we = 1; otherwise nothing.
- Flag update: on a non-squashed transfer with flag_we=1, carry_q <= alu_flags[2] at the same edge.
- Skid buffer:
  - 2-entry FIFO; the head drives wb_*.
  - Head pops when wb_valid and wb_ready.
  - A simultaneous push and pop when full is impossible, because in_ready=0.
  - A simultaneous push and pop at count 1 keeps count 1, and ordering is preserved.
  - When the buffer is empty, wb_data, wb_rd and wb_we hold their last values and wb_valid=0.
- Arithmetic: pc + 4 is modulo 2^XLEN, so 0xFFFFFFFC + 4 = 0.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined:
  - Adds output ports stat_branches[31:0] and stat_taken[31:0], both reset to 0.
  - stat_branches increments on every non-squashed branch transfer; stat_taken increments on every taken branch.
  - Both counters wrap at 2^32.
- Undefined: neither the ports nor the counters exist; all other behaviour is identical.

Decomposition:
- Package kgp_branch_pkg:
  - br_type codes: NONE=0, B=1, BR=2, BL=3, BLTZ=4, BZ=5, BNZ=6, BCY=7, BNCY=8.
  - Flag bit indices: CARRY=2, NEG=1, ZERO=0.
  - LINK_REG=31.
  - FSM state typedef.
- Sub-module: wb_skid_buffer (2-entry valid/ready FIFO), instantiated once.

Test Plan:
- Flag and BCY: ADD with flag_we and flags=3'b100, then BCY with br_target=0x40 -> carry_q=1, redirect pulses for 1 cycle with redirect_pc=0x40, and the next transfer is dropped.
- BZ/BNZ: alu_flags=3'b001 with BZ, target 0x80 -> redirect, redirect_pc=0x80. Same flags with BNZ -> no redirect; the transfer is consumed and the FSM stays in RUN.
- BL: pc=0x100, target 0x200 -> redirect_pc=0x200 and wb entry {0x104, rd=31, we=1}. With pc=0xFFFFFFFC -> wb_data=0.
- Backpressure: wb_ready=0 while three writes are offered -> in_ready=0 after 2 entries. When wb_ready is raised, entries drain in order with values 5, 6, 7.
- Reset mid-squash: taken B with SQUASH_DEPTH=1, then rst on the next cycle -> FSM=RUN and the next transfer is processed normally.
- BCY with flag_we in the same transfer, carry_q=0, alu_flags[2]=1 -> not taken; carry_q becomes 1 afterwards.
